// File: rtl/bs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bs_pkg
// Description : Shared widths, FSM state encoding and padding helpers for the
//               zlib bit-stream packer sequencer (bs_ctrl).
// Revision    : 1.0 - initial release
// ============================================================================
package bs_pkg;

  localparam int DATA_WD = 32;
  localparam int NUMB_WD = 5;
  localparam int PTR_WD  = 5;

  localparam int ST_WD = 2;
  localparam logic [ST_WD-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_WD-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_WD-1:0] ST_FLUSH = 2'd2;
  localparam logic [ST_WD-1:0] ST_DONE  = 2'd3;

  // Zero bits needed to reach the next byte boundary (0 when already aligned).
  function automatic logic [2:0] pad_byte(input logic [PTR_WD-1:0] ptr);
    return 3'd0 - ptr[2:0];
  endfunction

  // Length-1 code of the pad reaching the next 32-bit boundary; only
  // meaningful when ptr != 0.
  function automatic logic [NUMB_WD-1:0] pad_word(input logic [PTR_WD-1:0] ptr);
    return 5'd31 - ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bs_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : bs_rr_arb
// Description : Round-robin arbiter. Search starts one past the last granted
//               index and wraps; the pointer moves only when a grant is made.
// Revision    : 1.0 - initial release
// ============================================================================
module bs_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int IDX_WD = $clog2(NREQ);

  logic [IDX_WD-1:0] rr_q;
  logic [IDX_WD-1:0] rr_d;
  logic              found;

  // Two passes: indices above the pointer first, then the wrapped-around part.
  always_comb begin
    gnt_o = '0;
    rr_d  = rr_q;
    found = 1'b0;
    if (en_i) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_i[j] && (IDX_WD'(j) > rr_q)) begin
          gnt_o[j] = 1'b1;
          rr_d     = IDX_WD'(j);
          found    = 1'b1;
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_i[j] && (IDX_WD'(j) <= rr_q)) begin
          gnt_o[j] = 1'b1;
          rr_d     = IDX_WD'(j);
          found    = 1'b1;
        end
      end
    end
  end

  // Remember the last granted index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q <= '0;
    end else if (found) begin
      rr_q <= rr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bs_ctrl
// Description : Sequencer/arbiter sharing the bit-stream packer input among
//               NREQ requesters. Mirrors the packer bit pointer and inserts
//               zero padding for byte alignment and the final 32-bit flush.
//               Optional macro BS_CTRL_BITCNT_EN adds bitcnt_o (bits emitted
//               since start, including padding).
// Revision    : 1.0 - initial release
// ============================================================================
module bs_ctrl
  import bs_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    align_i,
  input  logic                    flush_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DATA_WD-1:0] dat_i,
  input  logic [NREQ*NUMB_WD-1:0] numb_i,
  output logic [NREQ-1:0]         ack_o,
  output logic                    val_o,
  output logic [DATA_WD-1:0]      dat_o,
  output logic [NUMB_WD-1:0]      numb_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef BS_CTRL_BITCNT_EN
  ,
  output logic [31:0]             bitcnt_o
`endif
);

  logic [ST_WD-1:0]   state_q;
  logic [ST_WD-1:0]   state_d;
  logic [PTR_WD-1:0]  ptr_q;
  logic               val_q;
  logic [DATA_WD-1:0] dat_q;
  logic [NUMB_WD-1:0] numb_q;

  logic               arb_en;
  logic [NREQ-1:0]    gnt;
  logic [DATA_WD-1:0] sel_dat;
  logic [NUMB_WD-1:0] sel_numb;
  logic [2:0]         pad_b;
  logic               emit_d;
  logic [DATA_WD-1:0] dat_d;
  logic [NUMB_WD-1:0] numb_d;

  // Requesters only compete in RUN cycles not claimed by flush or align.
  assign arb_en = (state_q == ST_RUN) && !flush_i && !align_i;

  bs_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req_i (req_i),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign ack_o = gnt;

  // One-hot OR-mux of the granted slot; zero when nothing is granted.
  always_comb begin
    sel_dat  = '0;
    sel_numb = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_dat  = sel_dat  | dat_i[k*DATA_WD +: DATA_WD];
        sel_numb = sel_numb | numb_i[k*NUMB_WD +: NUMB_WD];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush wins over align; start only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (flush_i) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Emission decision for this cycle: code word, byte pad or word pad.
  always_comb begin
    emit_d = 1'b0;
    dat_d  = '0;
    numb_d = '0;
    pad_b  = pad_byte(ptr_q);
    case (state_q)
      ST_RUN: begin
        if (flush_i) begin
          emit_d = 1'b0;
        end else if (align_i) begin
          if (pad_b != 3'd0) begin
            emit_d = 1'b1;
            numb_d = {2'b00, pad_b} - 5'd1;
          end
        end else begin
          emit_d = |gnt;
          dat_d  = sel_dat;
          numb_d = sel_numb;
        end
      end
      ST_FLUSH: begin
        if (ptr_q != '0) begin
          emit_d = 1'b1;
          numb_d = pad_word(ptr_q);
        end
      end
      default: emit_d = 1'b0;
    endcase
  end

  // Output registers and packer pointer mirror (5-bit wrap matches the packer).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q  <= 1'b0;
      dat_q  <= '0;
      numb_q <= '0;
      ptr_q  <= '0;
    end else begin
      val_q  <= emit_d;
      dat_q  <= dat_d;
      numb_q <= numb_d;
      if (emit_d) begin
        ptr_q <= ptr_q + numb_d + 5'd1;
      end
    end
  end

  assign val_o  = val_q;
  assign dat_o  = dat_q;
  assign numb_o = numb_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

`ifdef BS_CTRL_BITCNT_EN
  logic [31:0] bitcnt_q;

  // Running bit total for the current stream, held after DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bitcnt_q <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      bitcnt_q <= '0;
    end else if (emit_d) begin
      bitcnt_q <= bitcnt_q + {27'd0, numb_d} + 32'd1;
    end
  end

  assign bitcnt_o = bitcnt_q;
`endif

endmodule
`default_nettype wire
